// File: rtl/mac_ctrl_if.sv
// Bus bundle between mac_ctrl, the vector RAMs and the MAC unit.
// master = controller side, slave = RAM/MAC/host side.
interface mac_ctrl_if;
  logic        start;
  logic        abort;
  logic [4:0]  len;
  logic        busy;
  logic        done;
  logic [3:0]  rd_addr;
  logic        rd_en;
  logic [7:0]  rd_data_a;
  logic [7:0]  rd_data_b;
  logic [7:0]  mac_in1;
  logic [7:0]  mac_in2;
  logic        mac_clr;
  logic [25:0] mac_acc;
  logic [25:0] result;

  modport master (
    input  start, abort, len,
    input  rd_data_a, rd_data_b, mac_acc,
    output busy, done, rd_addr, rd_en,
    output mac_in1, mac_in2, mac_clr, result
  );

  modport slave (
    output start, abort, len,
    output rd_data_a, rd_data_b, mac_acc,
    input  busy, done, rd_addr, rd_en,
    input  mac_in1, mac_in2, mac_clr, result
  );
endinterface

// File: rtl/mac_ctrl.sv
// Dot-product sequencer: streams vector RAM reads into an external MAC.
// Define MAC_CTRL_RELU_EN to clamp negative captured results to zero.
module mac_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  mac_ctrl_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    CAPT
  } state_t;

  state_t      state;
  logic [3:0]  last;
  logic        zlen;
  logic [25:0] capt;

  assign bus.mac_in1 = bus.rd_data_a;
  assign bus.mac_in2 = bus.rd_data_b;
  assign bus.busy    = (state != IDLE);

`ifdef MAC_CTRL_RELU_EN
  assign capt = bus.mac_acc[25] ? '0 : bus.mac_acc;
`else
  assign capt = bus.mac_acc;
`endif

  // done rises together with the new result value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= '0;
      zlen        <= 1'b0;
      bus.rd_addr <= '0;
      bus.rd_en   <= 1'b0;
      bus.mac_clr <= 1'b0;
      bus.done    <= 1'b0;
      bus.result  <= '0;
    end else begin
      bus.done    <= 1'b0;
      bus.mac_clr <= bus.rd_en;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            if (bus.len == 5'd0) begin
              state      <= CAPT;
              zlen       <= 1'b1;
              bus.result <= '0;
              bus.done   <= 1'b1;
            end else begin
              state       <= RUN;
              zlen        <= 1'b0;
              bus.rd_addr <= '0;
              bus.rd_en   <= 1'b1;
              last        <= bus.len[4] ? 4'hf
                                        : bus.len[3:0] - 4'd1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state       <= IDLE;
            bus.rd_en   <= 1'b0;
            bus.mac_clr <= 1'b0;
          end else if (bus.rd_addr == last) begin
            state     <= DRAIN;
            bus.rd_en <= 1'b0;
          end else begin
            bus.rd_addr <= bus.rd_addr + 4'd1;
          end
        end
        DRAIN: begin
          if (bus.abort) begin
            state       <= IDLE;
            bus.mac_clr <= 1'b0;
          end else begin
            state <= CAPT;
          end
        end
        CAPT: begin
          state <= IDLE;
          if (!zlen) begin
            bus.result <= capt;
            bus.done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mac_ctrl.sv
// Scoreboard bench for mac_ctrl with behavioural vector RAMs and MAC.
// Expected results/latencies are queued at start and popped on done.
module tb_mac_ctrl;
  logic clk;
  logic rst_n;

  mac_ctrl_if bus ();

  mac_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic signed [31:0] res;
    int                 cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rd_cnt = 0;
  int n_done = 0;
  int n_exp  = 0;

  logic signed [7:0] ma [16];
  logic signed [7:0] mb [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // one-cycle-latency RAMs and a MAC with clear-low semantics
  always @(posedge clk) begin
    int p;
    cyc++;
    if (bus.rd_en) begin
      rd_cnt++;
      bus.rd_data_a <= ma[bus.rd_addr];
      bus.rd_data_b <= mb[bus.rd_addr];
    end
    p = int'($signed(bus.mac_in1)) * int'($signed(bus.mac_in2));
    bus.mac_acc <= bus.mac_clr ? bus.mac_acc + p[25:0] : '0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      n_done++;
      chk("done_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("result", $signed(bus.result), e.res);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic kick(input int l, input bit acc);
    int n;
    int s;
    exp_t e;
    @(negedge clk);
    bus.len   = 5'(l);
    bus.start = 1'b1;
    if (acc) begin
      n = (l > 16) ? 16 : l;
      s = 0;
      for (int i = 0; i < n; i++)
        s += int'(ma[i]) * int'(mb[i]);
`ifdef MAC_CTRL_RELU_EN
      if (s < 0) s = 0;
`endif
      e.res = s;
      e.cyc = cyc + ((n == 0) ? 1 : n + 3);
      q.push_back(e);
      n_exp++;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++)
      @(negedge clk);
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'(i + 1);
      mb[i] = 8'(i + 5);
    end
  endtask

  initial begin
    int r0;
    int relu_neg;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.len       = '0;
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    fill_seq();
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_mac_clr", bus.mac_clr, 0);
    chk("rst_result", $signed(bus.result), 0);
    rst_n = 1'b1;
    @(negedge clk);

    r0 = rd_cnt;
    kick(4, 1);
    drain(20);
    chk("rd_count_len4", rd_cnt - r0, 4);

    for (int i = 0; i < 16; i++) begin
      ma[i] = -8'sd128;
      mb[i] = -8'sd128;
    end
    kick(16, 1);
    drain(30);
    for (int i = 0; i < 16; i++) mb[i] = 8'sd127;
    kick(16, 1);
    drain(30);

    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'(i - 8);
      mb[i] = 8'sd3;
    end
    r0 = rd_cnt;
    kick(20, 1);
    drain(30);
    chk("rd_count_len20", rd_cnt - r0, 16);

    r0 = rd_cnt;
    kick(0, 1);
    drain(10);
    chk("rd_count_len0", rd_cnt - r0, 0);

    fill_seq();
    kick(4, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 5'd2;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    drain(20);

    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.len   = 5'd4;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", bus.busy, 0);
    chk("start_abort_rd_en", bus.rd_en, 0);

    kick(8, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("run_busy", bus.busy, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_en", bus.rd_en, 0);
    chk("abort_mac_clr", bus.mac_clr, 0);
    chk("abort_result", $signed(bus.result), 70);
    repeat (12) @(negedge clk);
    chk("abort_no_done", n_done, n_exp);

    ma[0] = 8'sd3;
    mb[0] = -8'sd2;
    relu_neg = -6;
`ifdef MAC_CTRL_RELU_EN
    relu_neg = 0;
`endif
    kick(1, 1);
    drain(10);
    chk("len1_result", $signed(bus.result), relu_neg);

    ma[0] = 8'sd2; ma[1] = 8'sd3;
    mb[0] = 8'sd4; mb[1] = 8'sd5;
    kick(2, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("capt_busy", bus.busy, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    drain(10);

    fill_seq();
    kick(10, 1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_rd_en", bus.rd_en, 0);
    chk("mid_rst_rd_addr", bus.rd_addr, 0);
    chk("mid_rst_mac_clr", bus.mac_clr, 0);
    chk("mid_rst_result", $signed(bus.result), 0);
    n_exp -= q.size();
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);

    kick(3, 1);
    drain(20);
    chk("done_count", n_done, n_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin dot product, sampled in IDLE only
- abort  in  1  cancel running operation
- len  in  5  vector length, 0..16, sampled with start
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- rd_addr  out  4  element address to vector RAMs
- rd_en  out  1  read strobe
- rd_data_a  in  8  signed element A, valid one cycle after rd_en
- rd_data_b  in  8  signed element B, valid one cycle after rd_en
- mac_in1  out  8  signed MAC operand 1
- mac_in2  out  8  signed MAC operand 2
- mac_clr  out  1  MAC control: 1 = accumulate (acc += in1*in2), 0 = clear acc to 0 at next edge
- mac_acc  in  26  signed MAC accumulator value
- result  out  26  signed captured dot product

Function
REQ-003 States SHALL be IDLE, RUN, DRAIN, CAPT.
REQ-004 IDLE: mac_clr=0, rd_en=0; on start=1: len!=0 -> RUN with addr counter=0; len=0 -> CAPT.
REQ-005 RUN: rd_en=1, rd_addr=counter; counter increments each cycle; after the read of address len-1 -> DRAIN.
REQ-006 mac_in1/mac_in2 SHALL equal rd_data_a/rd_data_b combinationally; mac_clr SHALL be a registered copy of rd_en (1 exactly in cycles where read data is valid).
REQ-007 DRAIN: rd_en=0, one cycle for the final accumulate to land -> CAPT.
REQ-008 CAPT: result <= mac_acc (0 when len=0), done=1 for this cycle, -> IDLE.
REQ-009 Latency: done SHALL assert exactly len+3 cycles after the edge sampling start (len>=1); 1 cycle for len=0.
REQ-010 len>16 SHALL be treated as 16.
REQ-011 start while busy SHALL be ignored; start and abort together in IDLE -> abort wins, stay IDLE.
REQ-012 abort in RUN/DRAIN SHALL return to IDLE next cycle, rd_en and mac_clr forced 0 that cycle, no done, result unchanged.
REQ-013 abort in CAPT SHALL be ignored (capture completes).
REQ-014 result SHALL hold its value until the next CAPT.
REQ-015 busy SHALL be 1 in RUN, DRAIN, CAPT.

Reset
REQ-016 rst_n low SHALL force IDLE, counter=0, result=0, done=0, busy=0, rd_en=0, rd_addr=0, mac_clr=0 immediately, regardless of clk.
REQ-017 Reset mid-operation SHALL discard the operation with no done pulse.

Configuration
REQ-018 With MAC_CTRL_RELU_EN defined, CAPT SHALL store 0 when mac_acc is negative, else mac_acc; without it, CAPT SHALL store mac_acc unmodified.
REQ-019 The macro SHALL NOT affect timing or any other output.

Verification
REQ-020 len=4, A={1,2,3,4}, B={5,6,7,8}: result=70, done at cycle 7 after start, single pulse.
REQ-021 len=16, all A=-128, all B=-128: result=262144; len=16, A=-128, B=127: result=-260096 (0 with MAC_CTRL_RELU_EN).
REQ-022 len=0: done 1 cycle after start, result=0, rd_en never asserted.
REQ-023 len=8, abort at cycle 4: IDLE next cycle, no done, result keeps prior value (70); new start len=1 A=3 B=-2 -> result=-6 (0 with RELU).
REQ-024 rst_n low during RUN of len=10: all outputs at reset values immediately; start pulses while busy ignored (done count equals accepted starts).
